// File: rtl/multistart_sequencer.sv
// rtl/multistart_sequencer.sv - sweeps a descent core over evenly spaced start points, keeping the lowest result
module multistart_sequencer #(
  parameter int MAX_STARTS     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  go,
  input  logic signed [31:0]                    x_first,
  input  logic signed [31:0]                    x_step,
  input  logic [$clog2(MAX_STARTS+1)-1:0]       num_starts,
  output logic                                  start_op,
  output logic signed [31:0]                    initial_x_out,
  input  logic                                  core_done,
  input  logic signed [31:0]                    core_x,
  input  logic signed [55:0]                    core_y,
  output logic signed [31:0]                    best_x,
  output logic signed [55:0]                    best_y,
  output logic [$clog2(MAX_STARTS)-1:0]         best_idx,
  output logic                                  busy,
  output logic                                  sweep_done,
  output logic                                  timeout_err
);

  localparam int CW = $clog2(MAX_STARTS + 1);
  localparam int IW = $clog2(MAX_STARTS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, CAPTURE, RELEASE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   run_idx_q;
  logic [TW-1:0]   tcnt_q;
  logic [CW-1:0]   num_clamped;
  logic            last_run;
  logic            launch_tmo;
  logic signed [32:0] x_sum;
  logic signed [31:0] x_next;

  always_comb begin
    num_clamped = num_starts;
    if (num_starts == '0)
      num_clamped = CW'(1);
    else if (num_starts > CW'(MAX_STARTS))
      num_clamped = CW'(MAX_STARTS);
  end

  // Next start point saturates instead of wrapping when the sweep runs off the Q24.8 range.
  always_comb begin
    x_sum  = {initial_x_out[31], initial_x_out} + {x_step[31], x_step};
    x_next = x_sum[31:0];
    if (x_sum[32] != x_sum[31])
      x_next = x_sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
  end

  assign last_run   = (CW'(run_idx_q + CW'(1)) == count_q);
  assign launch_tmo = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign start_op   = (state == LAUNCH);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = LAUNCH;
      LAUNCH:  if (core_done) state_nxt = CAPTURE;
               else if (launch_tmo) state_nxt = DONE;
      CAPTURE: state_nxt = RELEASE;
      RELEASE: if (!core_done) state_nxt = last_run ? DONE : LAUNCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      run_idx_q     <= '0;
      tcnt_q        <= '0;
      initial_x_out <= '0;
      best_x        <= '0;
      best_y        <= '0;
      best_idx      <= '0;
      busy          <= 1'b0;
      sweep_done    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          initial_x_out <= x_first;
          count_q       <= num_clamped;
          run_idx_q     <= '0;
          tcnt_q        <= '0;
          best_x        <= '0;
          best_y        <= '0;
          best_idx      <= '0;
          timeout_err   <= 1'b0;
          sweep_done    <= 1'b0;
          busy          <= 1'b1;
        end
        LAUNCH: if (!core_done) begin
          if (launch_tmo) begin
            timeout_err <= 1'b1;
            sweep_done  <= 1'b1;
            busy        <= 1'b0;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        // Strict compare keeps the earliest run on ties.
        CAPTURE: if (run_idx_q == '0 || core_y < best_y) begin
          best_x   <= core_x;
          best_y   <= core_y;
          best_idx <= run_idx_q[IW-1:0];
        end
        RELEASE: if (!core_done) begin
          if (last_run) begin
            sweep_done <= 1'b1;
            busy       <= 1'b0;
          end else begin
            run_idx_q     <= run_idx_q + CW'(1);
            initial_x_out <= x_next;
            tcnt_q        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multistart_sequencer.sv
// tb/tb_multistart_sequencer.sv - scoreboard bench for multistart_sequencer with a parabola core model
module tb_multistart_sequencer;

  localparam int LAT = 18;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               go = 1'b0;
  logic signed [31:0] x_first = '0;
  logic signed [31:0] x_step = '0;
  logic [3:0]         num_starts = '0;
  logic               start_op;
  logic signed [31:0] initial_x_out;
  logic               core_done;
  logic signed [31:0] core_x;
  logic signed [55:0] core_y;
  logic signed [31:0] best_x;
  logic signed [55:0] best_y;
  logic [2:0]         best_idx;
  logic               busy;
  logic               sweep_done;
  logic               timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int core_mode = 0;
  int starts_seen = 0;
  int hi_len = 0;
  logic prev_start = 1'b0;
  logic signed [31:0] exp_x[$];

  multistart_sequencer dut (
    .clk(clk), .rst_n(rst_n), .go(go), .x_first(x_first), .x_step(x_step),
    .num_starts(num_starts), .start_op(start_op), .initial_x_out(initial_x_out),
    .core_done(core_done), .core_x(core_x), .core_y(core_y), .best_x(best_x),
    .best_y(best_y), .best_idx(best_idx), .busy(busy), .sweep_done(sweep_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic signed [55:0] fy(input logic signed [31:0] x);
    logic signed [63:0] d;
    logic signed [63:0] p;
    d = x;
    d = d - 64'sd1024;
    p = d * d;
    return p[55:0];
  endfunction

  int core_cnt = 0;
  always @(posedge clk) begin
    if (!start_op) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
    end else if (!core_done) begin
      if (core_mode != 2 && core_cnt == LAT - 1) begin
        core_done <= 1'b1;
        core_x    <= initial_x_out;
        core_y    <= (core_mode == 1) ? 56'sd5 : fy(initial_x_out);
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (start_op && !prev_start) begin
      starts_seen++;
      hi_len = 1;
      if (exp_x.size() > 0)
        check("start_x", initial_x_out, exp_x.pop_front());
      else
        check("start_unexpected", 1, 0);
    end else if (start_op) begin
      hi_len++;
    end
    prev_start = start_op;
  end

  task automatic pulse_go();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic run_sweep(input logic signed [31:0] xf, input logic signed [31:0] xs,
                           input int n, input int md, input bit poke_go);
    int eff;
    logic signed [31:0] xi;
    logic signed [32:0] s;
    logic signed [55:0] yi, by;
    logic signed [31:0] bx;
    int bi;
    eff = (n == 0) ? 1 : (n > 8) ? 8 : n;
    xi = xf; by = '0; bx = '0; bi = 0;
    for (int i = 0; i < eff; i++) begin
      if (md != 2 || i == 0) exp_x.push_back(xi);
      yi = (md == 1) ? 56'sd5 : fy(xi);
      if (md != 2 && (i == 0 || yi < by)) begin by = yi; bx = xi; bi = i; end
      s = {xi[31], xi} + {xs[31], xs};
      xi = (s > 33'sh0_7FFF_FFFF) ? 32'sh7FFF_FFFF :
           (s < -33'sh0_8000_0000) ? 32'sh8000_0000 : s[31:0];
    end
    if (md == 2) eff = 1;
    core_mode = md; starts_seen = 0;
    x_first = xf; x_step = xs; num_starts = n[3:0];
    pulse_go();
    check("busy_on_go", busy, 1);
    check("done_clr_on_go", sweep_done, 0);
    if (poke_go) begin
      repeat (30) @(negedge clk);
      x_first = 32'sh1234;
      pulse_go();
    end
    for (int i = 0; i < 3000 && !sweep_done; i++) @(negedge clk);
    check("sweep_done", sweep_done, 1);
    check("busy_off", busy, 0);
    check("timeout_err", timeout_err, (md == 2));
    check("best_x", best_x, bx);
    check("best_y", best_y, by);
    check("best_idx", best_idx, bi[2:0]);
    check("runs", starts_seen, eff);
    check("queue_empty", exp_x.size(), 0);
    if (md == 2) check("tmo_len", hi_len, 64);
    @(negedge clk);
    check("done_held", sweep_done, 1);
    exp_x.delete();
  endtask

  initial begin
    #1;
    check("rst_start", start_op, 0);
    check("rst_x", initial_x_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", sweep_done, 0);
    check("rst_best_y", best_y, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_sweep(32'sh0, 32'sh200, 4, 0, 0);
    run_sweep(32'sh300, 32'sh100, 0, 0, 0);
    run_sweep(32'sh7FFF_FF00, 32'sh100, 3, 0, 0);
    run_sweep(32'sh100, 32'sh100, 2, 2, 0);
    run_sweep(32'sh700, 32'sh100, 3, 1, 1);
    run_sweep(-32'sh400, 32'sh100, 10, 0, 0);

    exp_x.push_back(32'sh0);
    exp_x.push_back(32'sh200);
    core_mode = 0; starts_seen = 0;
    x_first = 32'sh0; x_step = 32'sh200; num_starts = 4'd4;
    pulse_go();
    for (int i = 0; i < 500 && starts_seen < 2; i++) @(negedge clk);
    check("second_launch", starts_seen, 2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_start", start_op, 0);
    check("rst_mid_x", initial_x_out, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_best_x", best_x, 0);
    check("rst_mid_best_y", best_y, 0);
    check("rst_mid_done", sweep_done, 0);
    exp_x.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_resume_runs", starts_seen, 2);
    check("no_resume_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
